// File: rtl/network_sdiv_30s_14s_16_seq.sv
// network_sdiv_30s_14s_16_seq
// Sequential signed divider: 30-bit signed dividend / 14-bit signed divisor.
// Produces a 16-bit saturated quotient (truncated toward zero) and a 14-bit
// remainder carrying the dividend's sign. One radix-2 restoring step per
// enabled cycle, 30 steps, then a single sign-fix/saturate cycle.
// Valid/ready handshakes on input and output; one operation in flight.
module network_sdiv_30s_14s_16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [29:0] dividend,
    input  logic [13:0] divisor,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [15:0] quotient,
    output logic [13:0] remainder,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd29;

    state_t r_state;
    state_t w_state_next;

    // Operand and iteration state
    logic        r_sign_n;
    logic        r_sign_d;
    logic        r_dz_flag;
    logic [29:0] r_num;      // |dividend|, shifted left one bit per step
    logic [13:0] r_den;      // |divisor|
    logic [14:0] r_rem;      // partial remainder
    logic [29:0] r_quo;      // magnitude quotient, built MSB first
    logic [4:0]  r_cnt;

    // Output registers
    logic        r_out_vld;
    logic [15:0] r_quotient;
    logic [13:0] r_remainder;
    logic        r_ovf;
    logic        r_dz;

    // Handshake qualifiers
    logic w_accept;
    logic w_release;

    // Restoring step
    logic [15:0] w_trial;
    logic        w_ge;
    logic [14:0] w_rem_next;

    // Sign fix and saturation
    logic [30:0]        w_q_mag;
    logic signed [30:0] w_q_signed;
    logic [13:0]        w_r_signed;
    logic [15:0]        w_q_final;
    logic               w_ovf_final;

    assign in_rdy    = (r_state == IDLE);
    assign w_accept  = ce & in_vld & (r_state == IDLE);
    assign w_release = ce & r_out_vld & out_rdy & (r_state == OUT);

    // The partial remainder is always below |d| <= 8192, so the shifted trial
    // fits in 15 bits; the 16th bit only guards the compare.
    assign w_trial    = {r_rem, r_num[29]};
    assign w_ge       = (w_trial >= {2'b00, r_den});
    assign w_rem_next = w_ge ? (w_trial[14:0] - {1'b0, r_den}) : w_trial[14:0];

    // Signed quotient is computed at 31 bits so any 30-bit magnitude negates exactly.
    assign w_q_mag    = {1'b0, r_quo};
    assign w_q_signed = (r_sign_n ^ r_sign_d) ? -$signed(w_q_mag) : $signed(w_q_mag);
    assign w_r_signed = r_sign_n ? (14'd0 - r_rem[13:0]) : r_rem[13:0];

    // Saturate the quotient to 16 bits; divide-by-zero overrides everything.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_q_final   = w_q_signed[15:0];
        w_ovf_final = 1'b0;
        if (r_dz_flag) begin
            w_q_final   = r_sign_n ? 16'h8000 : 16'h7FFF;
            w_ovf_final = 1'b0;
        end else if (w_q_signed > 31'sd32767) begin
            w_q_final   = 16'h7FFF;
            w_ovf_final = 1'b1;
        end else if (w_q_signed < -31'sd32768) begin
            w_q_final   = 16'h8000;
            w_ovf_final = 1'b1;
        end
    end

    // State register; reset wins over ce, ce low freezes the FSM.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    if (r_cnt == LAST_ITER) w_state_next = FIX;
            FIX:     w_state_next = OUT;
            OUT:     if (w_release) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture and the restoring iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign_n  <= 1'b0;
            r_sign_d  <= 1'b0;
            r_dz_flag <= 1'b0;
            r_num     <= '0;
            r_den     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
        end else if (ce) begin
            if (w_accept) begin
                r_sign_n  <= dividend[29];
                r_sign_d  <= divisor[13];
                r_dz_flag <= (divisor == 14'd0);
                // Two's-complement negation gives the exact magnitude even for
                // the most negative values, read back as unsigned.
                r_num     <= dividend[29] ? (30'd0 - dividend) : dividend;
                r_den     <= divisor[13]  ? (14'd0 - divisor)  : divisor;
                r_rem     <= '0;
                r_quo     <= '0;
                r_cnt     <= '0;
            end else if (r_state == CALC) begin
                r_rem <= w_rem_next;
                r_quo <= {r_quo[28:0], w_ge};
                r_num <= {r_num[28:0], 1'b0};
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Result registers: loaded in FIX, held until the next FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else if (ce) begin
            if (r_state == FIX) begin
                r_out_vld   <= 1'b1;
                r_quotient  <= w_q_final;
                r_remainder <= r_dz_flag ? 14'd0 : w_r_signed;
                r_ovf       <= w_ovf_final;
                r_dz        <= r_dz_flag;
            end else if (w_release) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_vld   = r_out_vld;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule

// File: tb/tb_network_sdiv_30s_14s_16_seq.sv
// Testbench for network_sdiv_30s_14s_16_seq: directed vector table, handshake
// and stall corner sequences, and random operands against an arithmetic model.
module tb_network_sdiv_30s_14s_16_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_vld;
    logic        in_rdy;
    logic [29:0] dividend;
    logic [13:0] divisor;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] quotient;
    logic [13:0] remainder;
    logic        ovf;
    logic        dz;

    int n_checks = 0;
    int n_fail   = 0;

    network_sdiv_30s_14s_16_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint n;
        longint d;
        longint q;
        longint r;
        bit     ovf;
        bit     dz;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic (truncating division), then clamp.
    function automatic void model(input longint n, input longint d,
                                  output longint q, output longint r,
                                  output bit o, output bit z);
        longint q0;
        if (d == 0) begin
            z = 1'b1;
            o = 1'b0;
            q = (n < 0) ? -32768 : 32767;
            r = 0;
        end else begin
            z  = 1'b0;
            q0 = n / d;
            r  = n % d;
            o  = 1'b0;
            q  = q0;
            if (q0 > 32767) begin
                q = 32767;
                o = 1'b1;
            end else if (q0 < -32768) begin
                q = -32768;
                o = 1'b1;
            end
        end
    endfunction

    function automatic longint sq(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sr(input logic [13:0] v);
        return longint'($signed(v));
    endfunction

    // One full operation. mode 0: ce high; 1: ce low on edges 10..14;
    // 2: random ce. Returns results and edges from accept to visible out_vld.
    task automatic do_op(input longint n, input longint d, input int mode,
                         output longint q, output longint r,
                         output bit o, output bit z, output int lat);
        int guard;
        ce      = 1'b1;
        out_rdy = 1'b1;
        guard   = 0;
        while (!in_rdy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_rdy) check("in_rdy_wait_timeout", 0, 1);
        dividend = n[29:0];
        divisor  = d[13:0];
        in_vld   = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        lat    = 0;
        while (lat < 300) begin
            if (mode == 1)      ce = !((lat + 1) >= 10 && (lat + 1) <= 14);
            else if (mode == 2) ce = 1'($urandom_range(0, 1));
            else                ce = 1'b1;
            @(posedge clk);
            lat++;
            #1;
            if (out_vld) break;
        end
        if (!out_vld) check("out_vld_timeout", lat, -1);
        q  = sq(quotient);
        r  = sr(remainder);
        o  = ovf;
        z  = dz;
        ce = 1'b1;
        @(posedge clk); #1;
        check("release_out_vld", out_vld, 0);
        check("release_in_rdy", in_rdy, 1);
    endtask

    vec_t vecs[14];

    initial begin
        longint q, r, eq, er, q_hold, r_hold;
        bit o, z, eo, ez;
        int lat;

        vecs[0]  = '{1000, 7, 142, 6, 0, 0};
        vecs[1]  = '{-1000, 7, -142, -6, 0, 0};
        vecs[2]  = '{1000, -7, -142, 6, 0, 0};
        vecs[3]  = '{-1000, -7, 142, -6, 0, 0};
        vecs[4]  = '{536870911, 1, 32767, 0, 1, 0};
        vecs[5]  = '{-536870912, 1, -32768, 0, 1, 0};
        vecs[6]  = '{-32768, 1, -32768, 0, 0, 0};
        vecs[7]  = '{65535, 2, 32767, 1, 0, 0};
        vecs[8]  = '{-536870912, -8192, 32767, 0, 1, 0};
        vecs[9]  = '{12345, 0, 32767, 0, 0, 1};
        vecs[10] = '{-5, 0, -32768, 0, 0, 1};
        vecs[11] = '{0, 0, 32767, 0, 0, 1};
        vecs[12] = '{100, 3, 33, 1, 0, 0};
        vecs[13] = '{-8191, 8191, -1, 0, 0, 0};

        reset    = 1'b1;
        ce       = 1'b0;
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_in_rdy", in_rdy, 1);
        check("reset_out_vld", out_vld, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_ovf", ovf, 0);
        check("reset_dz", dz, 0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].n, vecs[i].d, 0, q, r, o, z, lat);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
            check($sformatf("vec%0d_dz", i), z, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), lat, 31);
        end

        // Results persist after out_vld falls (last vector: -1 / 0)
        repeat (3) @(posedge clk);
        #1;
        check("persist_q", sq(quotient), -1);
        check("persist_r", sr(remainder), 0);

        // ce stall of 5 cycles mid-CALC
        do_op(1000, 7, 1, q, r, o, z, lat);
        check("stall_q", q, 142);
        check("stall_r", r, 6);
        check("stall_latency", lat, 36);

        // Toggling ce gives the ungated result
        do_op(-1000, 7, 2, q, r, o, z, lat);
        check("toggle_q", q, -142);
        check("toggle_r", r, -6);

        // Backpressure: hold out_rdy low for 10 cycles with a competing in_vld
        ce       = 1'b1;
        out_rdy  = 1'b0;
        dividend = 30'd1000;
        divisor  = 14'd7;
        in_vld   = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        lat    = 0;
        while (!out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 31);
        q_hold   = sq(quotient);
        r_hold   = sr(remainder);
        check("bp_q", q_hold, 142);
        check("bp_r", r_hold, 6);
        dividend = 30'd50;
        divisor  = 14'd5;
        in_vld   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_vld", c), out_vld, 1);
            check($sformatf("bp_hold%0d_in_rdy", c), in_rdy, 0);
            check($sformatf("bp_hold%0d_q", c), sq(quotient), q_hold);
            check($sformatf("bp_hold%0d_r", c), sr(remainder), r_hold);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_vld", out_vld, 0);
        check("bp_release_in_rdy", in_rdy, 1);

        // Reset at edge 15 of CALC aborts the operation
        dividend = 30'd1000;
        divisor  = 14'd7;
        in_vld   = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_in_rdy", in_rdy, 1);
        check("rst_mid_out_vld", out_vld, 0);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_vld) lat++;
        end
        check("rst_mid_no_output", lat, 0);
        do_op(100, 3, 0, q, r, o, z, lat);
        check("after_rst_q", q, 33);
        check("after_rst_r", r, 1);
        check("after_rst_latency", lat, 31);

        // Random operands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            longint n, d;
            int mode;
            case ($urandom_range(0, 3))
                0: n = longint'($urandom_range(0, 32'h3FFFFFFF)) - 64'sd536870912;
                1: n = longint'($urandom_range(0, 2000)) - 1000;
                2: n = longint'($urandom_range(0, 131072)) - 65536;
                default: n = ($urandom_range(0, 1) == 1) ? -64'sd536870912 : 64'sd536870911;
            endcase
            case ($urandom_range(0, 3))
                0: d = longint'($urandom_range(0, 16383)) - 8192;
                1: d = longint'($urandom_range(0, 40)) - 20;
                2: d = ($urandom_range(0, 1) == 1) ? -64'sd8192 : 64'sd8191;
                default: d = (i % 10 == 0) ? 0 : longint'($urandom_range(1, 300));
            endcase
            mode = (i % 4 == 3) ? 2 : 0;
            model(n, d, eq, er, eo, ez);
            do_op(n, d, mode, q, r, o, z, lat);
            check($sformatf("rnd%0d_q(%0d/%0d)", i, n, d), q, eq);
            check($sformatf("rnd%0d_r(%0d/%0d)", i, n, d), r, er);
            check($sformatf("rnd%0d_ovf", i), o, eo);
            check($sformatf("rnd%0d_dz", i), z, ez);
            if (mode == 0) check($sformatf("rnd%0d_latency", i), lat, 31);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
